// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch/queue stage: default widths, the reset PC,
// the NOP encoding presented on an empty queue, and the queue entry layout.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int INSTR_W_DEF  = 16;
   localparam int PC_W_DEF     = 8;
   localparam int DEPTH_DEF    = 4;
   localparam int RESET_PC_DEF = 0;

   // Value driven on instr_out while the queue holds nothing.
   localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 16'h0000;

   // One buffered instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [INSTR_W_DEF-1:0] instr;
      logic [PC_W_DEF-1:0]    pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_stage_if
// Bundles the instruction-memory port, the redirect/stall controls from the
// pipeline and the decoder-facing instruction outputs of the fetch stage.
//   master : the fetch stage (drives imem_req/imem_addr and instr outputs)
//   slave  : the environment (memory, execute and decode stages)
// -----------------------------------------------------------------------------
interface fetch_queue_stage_if
   import fetch_pkg::*;
#(
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int PC_W    = PC_W_DEF
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               redirect_en;
   logic [PC_W-1:0]    redirect_pc;
   logic               stall;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr_out;
   logic [PC_W-1:0]    pc_out;

   modport master (
      output imem_req, imem_addr, instr_valid, instr_out, pc_out,
      input  imem_rdata, redirect_en, redirect_pc, stall
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr_out, pc_out,
      output imem_rdata, redirect_en, redirect_pc, stall
   );
endinterface

// File: rtl/fetch_queue_stage_instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
// Synchronous DEPTH-entry FIFO of fetch entries. Flush empties the queue and
// takes priority over a push in the same cycle.
//   clk_i, rst_n_i   : clock, synchronous active-low reset
//   push_i, pop_i    : enqueue push_entry_i / dequeue head_o at the edge
//   flush_i          : discard all entries
//   full_o, empty_o  : occupancy flags, count_o : number of entries
//   head_o           : oldest entry (contents undefined while empty)
// instr_queue_chk: assertion-only companion that flags a push into a full queue.
// -----------------------------------------------------------------------------
module instr_queue
   import fetch_pkg::*;
#(
   parameter type ENTRY_T = fetch_entry_t,
   parameter int  DEPTH   = DEPTH_DEF,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = PTR_W + 1
)(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  ENTRY_T           push_entry_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o,
   output ENTRY_T           head_o
);
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok_s, pop_ok_s;
   ENTRY_T           mem_q [DEPTH];

   // Pointer and occupancy next-state; pointers wrap naturally as DEPTH is 2^n.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      push_ok_s = push_i && !full_o;
      pop_ok_s  = pop_i && !empty_o;
      if (flush_i) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; needs no reset because empty_o masks stale contents.
   always_ff @(posedge clk_i) begin
      if (push_ok_s && !flush_i) begin
         mem_q[wr_ptr_q] <= push_entry_i;
      end
   end

   // Status flags and head-of-queue read.
   always_comb begin
      full_o  = (count_q == CNT_W'(DEPTH));
      empty_o = (count_q == {CNT_W{1'b0}});
      count_o = count_q;
      head_o  = mem_q[rd_ptr_q];
   end
endmodule

module instr_queue_chk (
   input logic clk_i,
   input logic rst_n_i,
   input logic push_i,
   input logic full_i
);
   // The credit scheme upstream must never let a response land on a full queue.
   a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                           !(push_i && full_i));
endmodule

// File: rtl/fetch_queue_stage.sv
// -----------------------------------------------------------------------------
// fetch_queue_stage
// Fetch stage: owns the PC, issues reads to a 1-cycle-latency instruction
// memory and buffers returned instructions with their PCs for the decoder.
//   clk, rst : clock, synchronous active-low reset
//   bus      : fetch_queue_stage_if.master
//              imem_req/imem_addr out, imem_rdata in (valid 1 cycle later)
//              redirect_en/redirect_pc in (flush + new PC), stall in
//              instr_valid/instr_out/pc_out out (head of queue, 0 when empty)
// -----------------------------------------------------------------------------
module fetch_queue_stage
   import fetch_pkg::*;
#(
   parameter int              INSTR_W  = INSTR_W_DEF,
   parameter int              PC_W     = PC_W_DEF,
   parameter int              DEPTH    = DEPTH_DEF,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
)(
   input logic                 clk,
   input logic                 rst,
   fetch_queue_stage_if.master bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } entry_t;

   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PC_W-1:0]  req_pc_q, req_pc_d;
   logic             inflight_q, inflight_d;
   logic             issue_s, push_s, pop_s, full_s, empty_s;
   logic [CNT_W-1:0] count_s, occ_s;
   entry_t           push_entry_s, head_s;

   // Credit check: a request is only issued if its response is guaranteed a slot,
   // counting the one still in flight. No issue while in reset or redirecting.
   always_comb begin
      occ_s = count_s + {{(CNT_W-1){1'b0}}, inflight_q};
      if ((rst == 1'b1) && (bus.redirect_en == 1'b0) && (occ_s < CNT_W'(DEPTH))) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
   end

   // PC / in-flight next state. Clearing inflight on redirect is implicit since
   // issue_s is 0 then; the response already returning is dropped by the flush.
   always_comb begin
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = issue_s;
      if (bus.redirect_en) begin
         pc_d = bus.redirect_pc;
      end else if (issue_s) begin
         pc_d     = pc_q + PC_W'(1);
         req_pc_d = pc_q;
      end else begin
         pc_d = pc_q;
      end
   end

   // PC, request-PC and in-flight registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= {PC_W{1'b0}};
         inflight_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
      end
   end

   // Queue controls: memory data returns the cycle after an issue.
   always_comb begin
      push_s             = inflight_q;
      push_entry_s.instr = bus.imem_rdata;
      push_entry_s.pc    = req_pc_q;
      pop_s              = !empty_s && !bus.stall;
   end

   instr_queue #(
      .ENTRY_T (entry_t),
      .DEPTH   (DEPTH)
   ) u_queue (
      .clk_i        (clk),
      .rst_n_i      (rst),
      .push_i       (push_s),
      .pop_i        (pop_s),
      .flush_i      (bus.redirect_en),
      .push_entry_i (push_entry_s),
      .full_o       (full_s),
      .empty_o      (empty_s),
      .count_o      (count_s),
      .head_o       (head_s)
   );

   instr_queue_chk u_queue_chk (
      .clk_i   (clk),
      .rst_n_i (rst),
      .push_i  (push_s),
      .full_i  (full_s)
   );

   // Memory request and decoder-facing outputs; zeros while the queue is empty.
   always_comb begin
      bus.imem_req    = issue_s;
      bus.imem_addr   = pc_q;
      bus.instr_valid = !empty_s;
      if (empty_s) begin
         bus.instr_out = INSTR_W'(NOP_INSTR);
         bus.pc_out    = {PC_W{1'b0}};
      end else begin
         bus.instr_out = head_s.instr;
         bus.pc_out    = head_s.pc;
      end
   end
endmodule
